// File: rtl/avalon_pio_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : avalon_pio_debounce
//  Purpose  : Avalon-MM PIO for key / switch / LED banks. Each input bit is
//             synchronised, debounced and edge-detected. Captured edges can
//             raise a masked, registered level interrupt. The output register
//             supports plain write plus atomic set and clear.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1          system clock
//    reset      in   1          asynchronous active-high reset
//    address    in   3          word address
//    read       in   1          read strobe (readdata valid one cycle later)
//    write      in   1          write strobe (takes effect on this edge)
//    writedata  in   32         write data
//    readdata   out  32         registered read data
//    irq        out  1          registered level interrupt
//    pio_in     in   IN_WIDTH   raw asynchronous inputs
//    pio_out    out  OUT_WIDTH  output register
// ----------------------------------------------------------------------------
//  Register map (word addresses, unused bits read 0)
//    0 DATA     R   debounced inputs
//    1 OUT      RW  output register
//    2 IRQMASK  RW  interrupt mask
//    3 EDGECAP  R/W1C captured edges
//    4 OUTSET   W   pio_out |= writedata   (reads 0)
//    5 OUTCLR   W   pio_out &= ~writedata  (reads 0)
//    6,7        reserved (reads 0)
// ============================================================================
module avalon_pio_debounce #(
    parameter int                   IN_WIDTH        = 10,
    parameter int                   OUT_WIDTH       = 10,
    parameter int                   DEBOUNCE_CYCLES = 50000,
    parameter int                   EDGE_TYPE       = 0,
    parameter logic [IN_WIDTH-1:0]  IN_RESET_VAL    = '0,
    parameter logic [OUT_WIDTH-1:0] OUT_RESET_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_cnt_w   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] c_addr_data    = 3'd0;
    localparam logic [2:0] c_addr_out     = 3'd1;
    localparam logic [2:0] c_addr_irqmask = 3'd2;
    localparam logic [2:0] c_addr_edgecap = 3'd3;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [IN_WIDTH-1:0]  r_sync1;
    logic [IN_WIDTH-1:0]  r_sync2;      // synchronised input ("s")
    logic [IN_WIDTH-1:0]  r_stable;     // debounced input
    logic [IN_WIDTH-1:0]  r_prev;       // r_stable delayed one cycle
    logic [IN_WIDTH-1:0]  r_irqmask;
    logic [IN_WIDTH-1:0]  r_edgecap;
    logic [OUT_WIDTH-1:0] r_out;
    logic [31:0]          r_readdata;
    logic                 r_irq;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [IN_WIDTH-1:0]  w_accept;     // bit whose new level is accepted now
    logic [IN_WIDTH-1:0]  w_edge;
    logic [IN_WIDTH-1:0]  w_w1c;
    logic [IN_WIDTH-1:0]  w_edgecap_nxt;
    logic [IN_WIDTH-1:0]  w_wd_in;
    logic [OUT_WIDTH-1:0] w_wd_out;
    logic [OUT_WIDTH-1:0] w_out_nxt;
    logic [31:0]          w_rd_mux;
    logic                 w_wr_out;
    logic                 w_wr_set;
    logic                 w_wr_clr;
    logic                 w_wr_mask;
    logic                 w_wr_ecap;
    logic                 w_unused_wd;

    assign w_wd_in     = writedata[IN_WIDTH-1:0];
    assign w_wd_out    = writedata[OUT_WIDTH-1:0];
    // Upper write-data bits beyond the bank widths are intentionally dropped.
    assign w_unused_wd = ^writedata;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= IN_RESET_VAL;
            r_sync2 <= IN_RESET_VAL;
        end else begin
            r_sync1 <= pio_in;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-bit debounce counter. The counter only runs while the synchronised
    // level disagrees with the accepted level; any agreement restarts it, so
    // a glitch shorter than DEBOUNCE_CYCLES leaves no trace. On expiry the
    // counter returns to 0, so it can never wrap.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_bit
        logic [c_cnt_w-1:0] r_cnt;
        logic               w_mismatch;
        logic               w_expire;

        assign w_mismatch  = r_sync2[i] ^ r_stable[i];
        assign w_expire    = w_mismatch && (r_cnt == c_cnt_max);
        assign w_accept[i] = w_expire;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (!w_mismatch || w_expire) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Accepting a bit means it takes the synchronised level, i.e. it toggles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= IN_RESET_VAL;
            r_prev   <= IN_RESET_VAL;
        end else begin
            r_stable <= r_stable ^ w_accept;
            r_prev   <= r_stable;
        end
    end

    // ------------------------------------------------------------------------
    // Edge selection. r_prev resets to the same value as r_stable, so reset
    // itself never produces an edge.
    // ------------------------------------------------------------------------
    if (EDGE_TYPE == 0) begin : g_edge_rise
        assign w_edge = r_stable & ~r_prev;
    end else if (EDGE_TYPE == 1) begin : g_edge_fall
        assign w_edge = ~r_stable & r_prev;
    end else begin : g_edge_any
        assign w_edge = r_stable ^ r_prev;
    end

    // ------------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------------
    assign w_wr_out  = write && (address == c_addr_out);
    assign w_wr_mask = write && (address == c_addr_irqmask);
    assign w_wr_ecap = write && (address == c_addr_edgecap);
    assign w_wr_set  = write && (address == 3'd4);
    assign w_wr_clr  = write && (address == 3'd5);

    always_comb begin
        w_out_nxt = r_out;
        if (w_wr_out) begin
            w_out_nxt = w_wd_out;
        end else if (w_wr_set) begin
            w_out_nxt = r_out | w_wd_out;
        end else if (w_wr_clr) begin
            w_out_nxt = r_out & ~w_wd_out;
        end
    end

    // A new edge is OR-ed in after the clear, so a simultaneous edge wins.
    assign w_w1c         = w_wr_ecap ? w_wd_in : '0;
    assign w_edgecap_nxt = (r_edgecap & ~w_w1c) | w_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out     <= OUT_RESET_VAL;
            r_irqmask <= '0;
            r_edgecap <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_out     <= w_out_nxt;
            r_edgecap <= w_edgecap_nxt;
            if (w_wr_mask) begin
                r_irqmask <= w_wd_in;
            end
            // Built from the registered capture and mask, hence one cycle
            // behind either of them changing.
            r_irq     <= |(r_edgecap & r_irqmask);
        end
    end

    // ------------------------------------------------------------------------
    // Read path. The mux sees pre-write register values, so a read and write
    // in the same cycle returns the old contents.
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_mux = '0;
        case (address)
            c_addr_data:    w_rd_mux[IN_WIDTH-1:0]  = r_stable;
            c_addr_out:     w_rd_mux[OUT_WIDTH-1:0] = r_out;
            c_addr_irqmask: w_rd_mux[IN_WIDTH-1:0]  = r_irqmask;
            c_addr_edgecap: w_rd_mux[IN_WIDTH-1:0]  = r_edgecap;
            default:        w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else if (read) begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;
    assign pio_out  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_avalon_pio_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avalon_pio_debounce
//  Purpose  : Self-checking bench for avalon_pio_debounce. Instance A uses
//             rising-edge capture with inputs resetting low; instance B uses
//             any-edge capture with two active-low keys resetting high.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_pio_debounce;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic [2:0]  addr_a, addr_b;
    logic        rd_a, rd_b, wr_a, wr_b;
    logic [31:0] wd_a, wd_b, rdata_a, rdata_b;
    logic        irq_a, irq_b;
    logic [9:0]  pin_a, pin_b, pout_a, pout_b;

    int n_checks = 0;
    int n_err    = 0;

    avalon_pio_debounce #(
        .IN_WIDTH(10), .OUT_WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0),
        .IN_RESET_VAL(10'h000), .OUT_RESET_VAL(10'h000)
    ) u_dut_a (
        .clk(clk), .reset(rst_a), .address(addr_a), .read(rd_a), .write(wr_a),
        .writedata(wd_a), .readdata(rdata_a), .irq(irq_a),
        .pio_in(pin_a), .pio_out(pout_a)
    );

    avalon_pio_debounce #(
        .IN_WIDTH(10), .OUT_WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2),
        .IN_RESET_VAL(10'h003), .OUT_RESET_VAL(10'h155)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .address(addr_b), .read(rd_b), .write(wr_b),
        .writedata(wd_b), .readdata(rdata_b), .irq(irq_b),
        .pio_in(pin_b), .pio_out(pout_b)
    );

    typedef struct {
        bit          is_rd;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [9:0]  exp_out;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input bit b, input logic [2:0] a, input logic [31:0] d);
        if (b) begin addr_b = a; wd_b = d; wr_b = 1'b1; end
        else   begin addr_a = a; wd_a = d; wr_a = 1'b1; end
        @(negedge clk);
        wr_a = 1'b0;
        wr_b = 1'b0;
    endtask

    task automatic bus_rd(input bit b, input logic [2:0] a, output logic [31:0] d);
        if (b) begin addr_b = a; rd_b = 1'b1; end
        else   begin addr_a = a; rd_a = 1'b1; end
        @(negedge clk);
        rd_a = 1'b0;
        rd_b = 1'b0;
        d = b ? rdata_b : rdata_a;
    endtask

    task automatic chk_rd(input bit b, input logic [2:0] a, input logic [31:0] exp, input string name);
        logic [31:0] d;
        bus_rd(b, a, d);
        chk(name, d, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;

        //            is_rd addr  wdata          exp_rd        exp_out
        tbl[0]  = '{1'b0, 3'd1, 32'h0000_00F0, 32'h0,        10'h0F0};
        tbl[1]  = '{1'b1, 3'd1, 32'h0,         32'h0000_00F0, 10'h0F0};
        tbl[2]  = '{1'b0, 3'd4, 32'h0000_0003, 32'h0,        10'h0F3};
        tbl[3]  = '{1'b0, 3'd5, 32'h0000_0010, 32'h0,        10'h0E3};
        tbl[4]  = '{1'b1, 3'd1, 32'h0,         32'h0000_00E3, 10'h0E3};
        tbl[5]  = '{1'b1, 3'd4, 32'h0,         32'h0,        10'h0E3};
        tbl[6]  = '{1'b1, 3'd5, 32'h0,         32'h0,        10'h0E3};
        tbl[7]  = '{1'b1, 3'd6, 32'h0,         32'h0,        10'h0E3};
        tbl[8]  = '{1'b0, 3'd7, 32'hFFFF_FFFF, 32'h0,        10'h0E3};
        tbl[9]  = '{1'b1, 3'd7, 32'h0,         32'h0,        10'h0E3};
        tbl[10] = '{1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0,        10'h0E3};
        tbl[11] = '{1'b1, 3'd0, 32'h0,         32'h0,        10'h0E3};
        tbl[12] = '{1'b0, 3'd2, 32'hFFFF_FFFF, 32'h0,        10'h0E3};
        tbl[13] = '{1'b1, 3'd2, 32'h0,         32'h0000_03FF, 10'h0E3};
        tbl[14] = '{1'b0, 3'd3, 32'hFFFF_FFFF, 32'h0,        10'h0E3};
        tbl[15] = '{1'b1, 3'd3, 32'h0,         32'h0,        10'h0E3};
        tbl[16] = '{1'b0, 3'd2, 32'h0,         32'h0,        10'h0E3};
        tbl[17] = '{1'b1, 3'd2, 32'h0,         32'h0,        10'h0E3};
        tbl[18] = '{1'b0, 3'd1, 32'hFFFF_F00F, 32'h0,        10'h00F};
        tbl[19] = '{1'b1, 3'd1, 32'h0,         32'h0000_000F, 10'h00F};
        tbl[20] = '{1'b0, 3'd1, 32'h0000_00F0, 32'h0,        10'h0F0};

        rst_a = 1'b1; rst_b = 1'b1;
        addr_a = '0; addr_b = '0; rd_a = 1'b0; rd_b = 1'b0; wr_a = 1'b0; wr_b = 1'b0;
        wd_a = '0; wd_b = '0;
        pin_a = 10'h000; pin_b = 10'h003;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_a_pio_out", 32'(pout_a), 32'h0);
        chk("rst_a_irq", 32'(irq_a), 32'h0);
        chk("rst_a_readdata", rdata_a, 32'h0);
        chk("rst_b_pio_out", 32'(pout_b), 32'h155);
        chk("rst_b_irq", 32'(irq_b), 32'h0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Register map vectors
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].is_rd) begin
                bus_rd(1'b0, tbl[i].addr, d);
                chk($sformatf("vec%0d_rd", i), d, tbl[i].exp_rd);
            end else begin
                bus_wr(1'b0, tbl[i].addr, tbl[i].wdata);
            end
            chk($sformatf("vec%0d_out", i), 32'(pout_a), 32'(tbl[i].exp_out));
        end

        // Read and write OUT together: read returns the old value
        addr_a = 3'd1; wd_a = 32'h123; rd_a = 1'b1; wr_a = 1'b1;
        @(negedge clk);
        rd_a = 1'b0; wr_a = 1'b0;
        chk("rdwr_readdata", rdata_a, 32'h0F0);
        chk("rdwr_pio_out", 32'(pout_a), 32'h123);

        // Debounce latency on bit 0, edge capture and irq, one cycle at a time
        bus_wr(1'b0, 3'd2, 32'h1);
        pin_a[0] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            addr_a = (k == 8) ? 3'd3 : 3'd0;
            rd_a   = 1'b1;
            @(negedge clk);
            if (k < 8) chk($sformatf("lat_data_k%0d", k), rdata_a, (k == 7) ? 32'h1 : 32'h0);
            else       chk("lat_edgecap", rdata_a, 32'h1);
            chk($sformatf("lat_irq_k%0d", k), 32'(irq_a), (k == 8) ? 32'h1 : 32'h0);
        end
        rd_a = 1'b0;

        // W1C clears; irq follows one cycle later
        bus_wr(1'b0, 3'd3, 32'h1);
        chk("w1c_irq_still_set", 32'(irq_a), 32'h1);
        @(negedge clk);
        chk("w1c_irq_cleared", 32'(irq_a), 32'h0);
        chk_rd(1'b0, 3'd3, 32'h0, "w1c_edgecap");

        // Two 3-cycle glitches on bit 3 are discarded
        pin_a[3] = 1'b1; repeat (3) @(negedge clk);
        pin_a[3] = 1'b0; repeat (3) @(negedge clk);
        pin_a[3] = 1'b1; repeat (3) @(negedge clk);
        pin_a[3] = 1'b0; repeat (10) @(negedge clk);
        chk_rd(1'b0, 3'd0, 32'h1, "glitch_data");
        chk_rd(1'b0, 3'd3, 32'h0, "glitch_edgecap");
        chk("glitch_irq", 32'(irq_a), 32'h0);

        // Masked-off edge on bit 2
        pin_a[2] = 1'b1; repeat (10) @(negedge clk);
        chk_rd(1'b0, 3'd3, 32'h4, "mask_edgecap");
        chk("mask_irq", 32'(irq_a), 32'h0);
        chk_rd(1'b0, 3'd0, 32'h5, "mask_data");
        bus_wr(1'b0, 3'd3, 32'h4);
        chk_rd(1'b0, 3'd3, 32'h0, "mask_w1c");

        // Falling edge ignored in rising mode, then W1C races a new edge
        pin_a[0] = 1'b0; repeat (10) @(negedge clk);
        chk_rd(1'b0, 3'd3, 32'h0, "fall_ignored");
        chk_rd(1'b0, 3'd0, 32'h4, "fall_data");
        pin_a[0] = 1'b1; repeat (6) @(negedge clk);
        bus_wr(1'b0, 3'd3, 32'h1);
        chk_rd(1'b0, 3'd3, 32'h1, "race_set_wins");
        chk("race_irq", 32'(irq_a), 32'h1);

        // Instance B: active-low keys, any-edge capture
        chk_rd(1'b1, 3'd0, 32'h3, "b_rst_data");
        chk_rd(1'b1, 3'd3, 32'h0, "b_rst_edgecap");
        chk_rd(1'b1, 3'd1, 32'h155, "b_rst_out");
        pin_b[1] = 1'b0; repeat (8) @(negedge clk);
        chk_rd(1'b1, 3'd3, 32'h2, "b_fall_edgecap");
        chk("b_irq_unmasked", 32'(irq_b), 32'h0);
        bus_wr(1'b1, 3'd2, 32'h2);
        chk("b_irq_mask_edge", 32'(irq_b), 32'h0);
        @(negedge clk);
        chk("b_irq_mask_next", 32'(irq_b), 32'h1);
        chk_rd(1'b1, 3'd0, 32'h1, "b_fall_data");
        bus_wr(1'b1, 3'd3, 32'h2);
        @(negedge clk);
        chk("b_irq_cleared", 32'(irq_b), 32'h0);
        pin_b[1] = 1'b1; repeat (8) @(negedge clk);
        chk_rd(1'b1, 3'd3, 32'h2, "b_rise_edgecap");
        chk_rd(1'b1, 3'd0, 32'h3, "b_rise_data");
        bus_wr(1'b1, 3'd1, 32'h0AA);
        chk("b_out_written", 32'(pout_b), 32'h0AA);
        chk("b_irq_before_rst", 32'(irq_b), 32'h1);

        // Asynchronous reset in the middle of a debounce count
        pin_b[1] = 1'b0; repeat (4) @(negedge clk);
        #2 rst_b = 1'b1;
        #1;
        chk("b_arst_pio_out", 32'(pout_b), 32'h155);
        chk("b_arst_irq", 32'(irq_b), 32'h0);
        chk("b_arst_readdata", rdata_b, 32'h0);
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        chk_rd(1'b1, 3'd3, 32'h0, "b_post_rst_edgecap");
        chk_rd(1'b1, 3'd0, 32'h3, "b_post_rst_data");
        chk_rd(1'b1, 3'd2, 32'h0, "b_post_rst_mask");
        repeat (10) @(negedge clk);
        chk_rd(1'b1, 3'd3, 32'h2, "b_post_rst_transition");
        chk_rd(1'b1, 3'd0, 32'h1, "b_post_rst_data2");
        chk("b_post_rst_irq", 32'(irq_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
